mem_arbiter: RTL and testbench

- Arbitrates the CPU's single-port 256x8 memory between two requesters:
  - port 0: the CPU core (fetch, LOAD/STORE).
  - port 1: a loader/debug master that writes programs and reads results.
- Sits between `cpu` and `mem_unit`, replacing the direct CPU-to-memory connection.
- Provides `cpu_hold` so the loader can freeze the core while it owns memory (boot load, debug peek/poke).

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Handles one access at a time (IDLE -> ISSUE -> RESP) with round-robin or fixed priority.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter bit          RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_hold,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;   // 1 = port 1 owns the access
    logic              last_q, last_d;     // last granted port
    logic              rd_q, rd_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              busy_q, busy_d;
    logic              elig0, elig1, win1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        rd_d        = rd_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;

        elig0 = m0_req && !m1_lock;
        elig1 = m1_req;
        if (elig0 && elig1) begin
            win1 = RR_EN ? !last_q : 1'b1;
        end else begin
            win1 = elig1;
        end

        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    state_d     = ISSUE;
                    owner_d     = win1;
                    last_d      = win1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = win1 ? m1_we : m0_we;
                    rd_d        = win1 ? !m1_we : !m0_we;
                    mem_addr_d  = win1 ? m1_addr : m0_addr;
                    mem_wdata_d = win1 ? m1_wdata : m0_wdata;
                end
            end
            ISSUE: begin
                state_d  = RESP;
                mem_we_d = 1'b0;
                m0_ack_d = !owner_q;
                m1_ack_d = owner_q;
            end
            RESP: begin
                // Return to IDLE without sampling requests on this edge.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cpu_hold_d = m1_lock || ((state_d != IDLE) && owner_d);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            rd_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            rd_q        <= rd_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
        end
    end

    // Memory read data is only valid in RESP, so it is passed through gated by the ack.
    assign m0_rdata  = (m0_ack_q && rd_q) ? mem_rdata : '0;
    assign m1_rdata  = (m1_ack_q && rd_q) ? mem_rdata : '0;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin and fixed-priority instances share stimulus,
// each backed by its own 256x8 synchronous memory; acks are checked against a scoreboard.
module tb_mem_arbiter;

    logic       clk, reset;
    logic       m0_req, m0_we, m1_req, m1_we, m1_lock;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic       m0_ack_rr, m1_ack_rr, mem_en_rr, mem_we_rr, cpu_hold_rr, busy_rr;
    logic [7:0] m0_rdata_rr, m1_rdata_rr, mem_addr_rr, mem_wdata_rr, mem_rdata_rr;
    logic       m0_ack_fp, m1_ack_fp, mem_en_fp, mem_we_fp, cpu_hold_fp, busy_fp;
    logic [7:0] m0_rdata_fp, m1_rdata_fp, mem_addr_fp, mem_wdata_fp, mem_rdata_fp;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    logic [7:0] ref_mem [256];
    logic [7:0] prog [6];

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    bit         order_q[$];

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack_rr), .m0_rdata(m0_rdata_rr),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ack(m1_ack_rr), .m1_rdata(m1_rdata_rr),
        .mem_en(mem_en_rr), .mem_we(mem_we_rr), .mem_addr(mem_addr_rr),
        .mem_wdata(mem_wdata_rr), .mem_rdata(mem_rdata_rr),
        .cpu_hold(cpu_hold_rr), .busy(busy_rr)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack_fp), .m0_rdata(m0_rdata_fp),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_lock(m1_lock), .m1_ack(m1_ack_fp), .m1_rdata(m1_rdata_fp),
        .mem_en(mem_en_fp), .mem_we(mem_we_fp), .mem_addr(mem_addr_fp),
        .mem_wdata(mem_wdata_fp), .mem_rdata(mem_rdata_fp),
        .cpu_hold(cpu_hold_fp), .busy(busy_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en_rr) begin
            if (mem_we_rr) mem_a[mem_addr_rr] <= mem_wdata_rr;
            mem_rdata_rr <= mem_a[mem_addr_rr];
        end
        if (mem_en_fp) begin
            if (mem_we_fp) mem_b[mem_addr_fp] <= mem_wdata_fp;
            mem_rdata_fp <= mem_b[mem_addr_fp];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every ack of the round-robin instance pops an expectation.
    always @(negedge clk) begin
        if (m0_ack_rr || m1_ack_rr) begin
            check("ack_exclusive", {63'd0, m0_ack_rr & m1_ack_rr}, 64'd0);
            if (order_q.size() > 0) check("grant_order", {63'd0, m1_ack_rr}, {63'd0, order_q.pop_front()});
        end
        if (m0_ack_rr) begin
            if (exp_q0.size() == 0) check("m0_unexpected_ack", {63'd0, m0_ack_rr}, 64'd0);
            else check("m0_rdata", {56'd0, m0_rdata_rr}, {56'd0, exp_q0.pop_front()});
        end
        if (m1_ack_rr) begin
            if (exp_q1.size() == 0) check("m1_unexpected_ack", {63'd0, m1_ack_rr}, 64'd0);
            else check("m1_rdata", {56'd0, m1_rdata_rr}, {56'd0, exp_q1.pop_front()});
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rr"}, {m0_ack_rr, m1_ack_rr, m0_rdata_rr, m1_rdata_rr, mem_en_rr, mem_we_rr,
                             mem_addr_rr, mem_wdata_rr, cpu_hold_rr, busy_rr}, 64'd0);
        check({tag, "_fp"}, {m0_ack_fp, m1_ack_fp, m0_rdata_fp, m1_rdata_fp, mem_en_fp, mem_we_fp,
                             mem_addr_fp, mem_wdata_fp, cpu_hold_fp, busy_fp}, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero(tag);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Single uncontended access; caller is at a negedge with the arbiter idle.
    task automatic do_access(input bit port, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int cyc;
        logic [7:0] exp;
        exp = we ? 8'h00 : ref_mem[addr];
        if (we) ref_mem[addr] = wdata;
        if (port) begin
            exp_q1.push_back(exp);
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
        end else begin
            exp_q0.push_back(exp);
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
        end
        cyc = 0;
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("issue_mem_en", {63'd0, mem_en_rr}, 64'd1);
                check("issue_mem_we", {63'd0, mem_we_rr}, {63'd0, we});
                check("issue_mem_addr", {56'd0, mem_addr_rr}, {56'd0, addr});
                check("issue_mem_wdata", {56'd0, mem_wdata_rr}, {56'd0, wdata});
                check("issue_busy", {63'd0, busy_rr}, 64'd1);
            end
            if (cyc == 2) check("resp_mem_en", {63'd0, mem_en_rr}, 64'd0);
            check("cpu_hold", {63'd0, cpu_hold_rr}, {63'd0, port | m1_lock});
            check("other_ack", {63'd0, port ? m0_ack_rr : m1_ack_rr}, 64'd0);
            if (port ? m1_ack_rr : m0_ack_rr) break;
        end
        check("ack_latency", 64'(cyc), 64'd2);
        if (port) m1_req = 1'b0; else m0_req = 1'b0;
        @(negedge clk);
        check("busy_after", {63'd0, busy_rr}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n_rr, n_fp;
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'h00; mem_b[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        prog[0] = 8'h63; prog[1] = 8'h73; prog[2] = 8'h04;
        prog[3] = 8'hE0; prog[4] = 8'h02; prog[5] = 8'h01;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;

        @(negedge clk);
        do_reset("reset_state");

        // Loader write then read back, CPU idle.
        do_access(1'b1, 1'b1, 8'h00, 8'h63);
        do_access(1'b1, 1'b0, 8'h00, 8'h5A);

        // Loader owns memory under lock while the CPU waits on a fetch.
        m1_lock = 1'b1;
        m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_req = 1'b1;
        exp_q0.push_back(prog[0]);
        @(negedge clk);
        check("hold_on_lock", {63'd0, cpu_hold_rr}, 64'd1);
        check("no_grant_locked", {63'd0, mem_en_rr}, 64'd0);
        for (int i = 0; i < 6; i++) do_access(1'b1, 1'b1, 8'(i), prog[i]);
        repeat (3) begin
            @(negedge clk);
            check("locked_m0_ack", {63'd0, m0_ack_rr}, 64'd0);
            check("locked_idle", {63'd0, mem_en_rr}, 64'd0);
        end
        m1_lock = 1'b0;
        cyc = 0;
        while (cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("hold_released", {63'd0, cpu_hold_rr}, 64'd0);
            if (m0_ack_rr) break;
        end
        check("m0_fetch_latency", 64'(cyc), 64'd2);
        m0_req = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) check("prog_in_mem", {56'd0, mem_a[i]}, {56'd0, prog[i]});

        // Lock rises while a port 0 write is in ISSUE.
        m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 8'hAA; m0_req = 1'b1;
        exp_q0.push_back(8'h00);
        ref_mem[8'h10] = 8'hAA;
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        @(negedge clk);
        check("m0_in_issue", {63'd0, mem_en_rr}, 64'd1);
        m1_lock = 1'b1;
        m1_we = 1'b0; m1_addr = 8'h10; m1_wdata = 8'h00; m1_req = 1'b1;
        exp_q1.push_back(8'hAA);
        @(negedge clk);
        check("m0_ack_under_lock", {63'd0, m0_ack_rr}, 64'd1);
        cyc = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (m1_ack_rr) break;
        end
        check("m1_after_lock", 64'(cyc), 64'd3);
        m1_req = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("m0_blocked_by_lock", {63'd0, mem_en_rr}, 64'd0);
        end
        m0_req = 1'b0;
        m1_lock = 1'b0;
        @(negedge clk);
        check("mem_0x10", {56'd0, mem_a[8'h10]}, 64'hAA);

        // Continuous contention on both ports from reset.
        do_reset("reset_state2");
        m0_we = 1'b0; m0_addr = 8'h01; m0_wdata = 8'h00; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 8'h02; m1_wdata = 8'h00; m1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            order_q.push_back(1'b1);
            order_q.push_back(1'b0);
            exp_q1.push_back(ref_mem[8'h02]);
            exp_q0.push_back(ref_mem[8'h01]);
        end
        n_rr = 0;
        n_fp = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (m0_ack_rr || m1_ack_rr) begin
                check("rr_spacing", 64'(c), 64'(2 + 3 * n_rr));
                n_rr++;
            end
            if (m0_ack_fp || m1_ack_fp) begin
                check("fp_m0_starved", {63'd0, m0_ack_fp}, 64'd0);
                check("fp_winner", {63'd0, m1_ack_fp}, 64'd1);
                check("fp_rdata", {56'd0, m1_rdata_fp}, {56'd0, ref_mem[8'h02]});
                check("fp_spacing", 64'(c), 64'(2 + 3 * n_fp));
                n_fp++;
            end
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
        check("rr_grants", 64'(n_rr), 64'd6);
        check("fp_grants", 64'(n_fp), 64'd6);

        // Reset during RESP of a port 0 read.
        m0_we = 1'b0; m0_addr = 8'h05; m0_wdata = 8'h00; m0_req = 1'b1;
        exp_q0.push_back(ref_mem[8'h05]);
        repeat (2) @(negedge clk);
        check("resp_ack", {63'd0, m0_ack_rr}, 64'd1);
        reset = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_in_resp");
        reset = 1'b0;
        @(negedge clk);

        // Reset during ISSUE: the access is dropped and no ack follows.
        m0_we = 1'b0; m0_addr = 8'h03; m0_req = 1'b1;
        @(negedge clk);
        check("issue_before_reset", {63'd0, mem_en_rr}, 64'd1);
        reset = 1'b1;
        m0_req = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_in_issue");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Service resumes normally.
        do_access(1'b0, 1'b0, 8'h03, 8'h00);
        repeat (2) @(negedge clk);

        check("q0_drained", 64'(exp_q0.size()), 64'd0);
        check("q1_drained", 64'(exp_q1.size()), 64'd0);
        check("order_drained", 64'(order_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
